// File: rtl/apb2axi_axi_slave_mem.sv
// AXI3 slave responder over a word-addressed memory: one write and one read outstanding, independent paths.
// Optional macro APB2AXI_SLV_RD_LAT_EN adds an R_WAIT state so the first read beat arrives RD_LAT cycles after AR.
module apb2axi_axi_slave_mem #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LAT     = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [AXI_ID_W-1:0]     AWID,
  input  logic [AXI_ADDR_W-1:0]   AWADDR,
  input  logic [3:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic [1:0]              AWLOCK,
  input  logic [3:0]              AWCACHE,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [AXI_DATA_W-1:0]   WDATA,
  input  logic [AXI_DATA_W/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [AXI_ID_W-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [AXI_ID_W-1:0]     ARID,
  input  logic [AXI_ADDR_W-1:0]   ARADDR,
  input  logic [3:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [1:0]              ARLOCK,
  input  logic [3:0]              ARCACHE,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [AXI_ID_W-1:0]     RID,
  output logic [AXI_DATA_W-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [3:0]              dbg_state
);
  // Handshakes: a transfer happens on a rising edge where VALID and READY are both high; this slave
  // never makes VALID depend on READY and holds its outputs stable until the transfer completes.
  localparam int STRB_W     = AXI_DATA_W / 8;
  localparam int OFF_W      = $clog2(STRB_W);
  localparam int IDX_W      = $clog2(MEM_DEPTH);
  localparam int RD_LAT_EFF = (RD_LAT < 1) ? 1 : RD_LAT;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00, BURST_INCR = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  function automatic logic [1:0] beat_status(input logic [AXI_ADDR_W-1:0] addr,
                                             input logic [2:0] size, input logic [1:0] burst);
    logic [1:0] st;
    st = OKAY;
    if ((burst != BURST_FIXED && burst != BURST_INCR) || size > 3'(OFF_W)) st = SLVERR;
    if ((addr >> OFF_W) >= AXI_ADDR_W'(MEM_DEPTH)) st = DECERR;
    return st;
  endfunction

  function automatic logic [AXI_ADDR_W-1:0] next_addr(input logic [AXI_ADDR_W-1:0] addr,
                                                      input logic [2:0] size, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + (AXI_ADDR_W'(1) << size);
  endfunction

  // Response codes are ordered so the numerically larger one is the more severe.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic [AXI_ID_W-1:0]   w_id_q, w_id_d;
  logic [AXI_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [3:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d, w_resp_q, w_resp_d;
  logic                  rdy_en_q, rdy_en_d;
  r_state_e              r_state_q, r_state_d;
  logic [AXI_ID_W-1:0]   r_id_q, r_id_d;
  logic [AXI_ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [3:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d, rresp_q, rresp_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
`ifdef APB2AXI_SLV_RD_LAT_EN
  logic [7:0]            r_wait_q, r_wait_d;
`endif

  logic                  mem_we;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_st;
  logic                  w_len_hit;
  logic                  rd_load;
  logic [AXI_ADDR_W-1:0] rd_addr;
  logic [2:0]            rd_size;
  logic [1:0]            rd_burst, rd_st;
  logic                  unused_ok;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_resp_d  = w_resp_q;
    rdy_en_d  = 1'b1;
    mem_we    = 1'b0;
    w_idx     = w_addr_q[OFF_W +: IDX_W];
    w_st      = beat_status(w_addr_q, w_size_q, w_burst_q);
    w_len_hit = (w_cnt_q == w_len_q);
    case (w_state_q)
      W_IDLE: if (AWVALID && AWREADY) begin
        w_id_d    = AWID;
        w_addr_d  = AWADDR;
        w_len_d   = AWLEN;
        w_size_d  = AWSIZE;
        w_burst_d = AWBURST;
        w_cnt_d   = '0;
        w_resp_d  = OKAY;
        w_state_d = W_DATA;
      end
      W_DATA: if (WVALID) begin
        mem_we   = (w_st == OKAY);
        // A WLAST that disagrees with the beat count ends the burst early or flags it, never both silently.
        w_resp_d = resp_max(w_resp_q, (WLAST != w_len_hit) ? resp_max(w_st, SLVERR) : w_st);
        if (w_len_hit || WLAST) begin
          w_state_d = W_RESP;
        end else begin
          w_cnt_d  = w_cnt_q + 4'd1;
          w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
        end
      end
      W_RESP: if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
`ifdef APB2AXI_SLV_RD_LAT_EN
    r_wait_d  = r_wait_q;
`endif
    rd_load   = 1'b0;
    rd_addr   = r_addr_q;
    rd_size   = r_size_q;
    rd_burst  = r_burst_q;
    case (r_state_q)
      R_IDLE: if (ARVALID && ARREADY) begin
        r_id_d    = ARID;
        r_addr_d  = ARADDR;
        r_len_d   = ARLEN;
        r_size_d  = ARSIZE;
        r_burst_d = ARBURST;
        r_cnt_d   = '0;
        rd_addr   = ARADDR;
        rd_size   = ARSIZE;
        rd_burst  = ARBURST;
`ifdef APB2AXI_SLV_RD_LAT_EN
        if (RD_LAT_EFF > 1) begin
          r_state_d = R_WAIT;
          r_wait_d  = 8'(RD_LAT_EFF - 1);
        end else begin
          r_state_d = R_DATA;
          rd_load   = 1'b1;
        end
`else
        r_state_d = R_DATA;
        rd_load   = 1'b1;
`endif
      end
`ifdef APB2AXI_SLV_RD_LAT_EN
      // Leaving on the count of 1 puts the first RVALID exactly RD_LAT cycles after the AR handshake.
      R_WAIT: if (r_wait_q <= 8'd1) begin
        r_state_d = R_DATA;
        rd_load   = 1'b1;
      end else begin
        r_wait_d = r_wait_q - 8'd1;
      end
`endif
      R_DATA: if (RREADY) begin
        if (r_cnt_q == r_len_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d  = r_cnt_q + 4'd1;
          r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
          rd_addr  = r_addr_d;
          rd_load  = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    rd_st = beat_status(rd_addr, rd_size, rd_burst);
    // Beat data is captured when the beat is presented, so a same-cycle write is seen by the next beat only.
    if (rd_load) begin
      rresp_d = rd_st;
      rdata_d = (rd_st == OKAY) ? mem[rd_addr[OFF_W +: IDX_W]] : '0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_resp_q  <= OKAY;
      rdy_en_q  <= 1'b0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
`ifdef APB2AXI_SLV_RD_LAT_EN
      r_wait_q  <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_resp_q  <= w_resp_d;
      rdy_en_q  <= rdy_en_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
`ifdef APB2AXI_SLV_RD_LAT_EN
      r_wait_q  <= r_wait_d;
`endif
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  assign AWREADY   = (w_state_q == W_IDLE) && rdy_en_q;
  assign WREADY    = (w_state_q == W_DATA);
  assign BVALID    = (w_state_q == W_RESP);
  assign BID       = w_id_q;
  assign BRESP     = w_resp_q;
  assign ARREADY   = (r_state_q == R_IDLE) && rdy_en_q;
  assign RVALID    = (r_state_q == R_DATA);
  assign RID       = r_id_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign RLAST     = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
  assign dbg_state = {w_state_q, r_state_q};

`ifdef APB2AXI_SLV_RD_LAT_EN
  assign unused_ok = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};
`else
  assign unused_ok = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT, (RD_LAT_EFF > 1)};
`endif
endmodule
